pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Measures an external PWM waveform (the input-side counterpart of the PWM output channels).
//  Synchronises pwm_in, times high phase and full period in prescaled ticks and publishes both
//  on every rising edge. Flags a stuck line on counter saturation. Optionally computes 8-bit duty.
// PARAMETERS
//  CNT_W        16  width of tick counters and high_count/period_count
//  SYNC_STAGES  2   synchroniser flops on pwm_in (>=2)
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      reset, asynchronous, active-low
//  pwm_in         in   1      asynchronous PWM input
//  en             in   1      capture enable
//  reg_capture_divider in 4   tick = every 2^div clk cycles (0..15)
//  high_count     out  CNT_W  ticks of last high phase
//  period_count   out  CNT_W  ticks of last full period
//  meas_valid     out  1      1-cycle pulse when new counts published
//  stuck          out  1      line saw no edge for 2^CNT_W-1 ticks
//  stuck_level    out  1      synchronised level when stuck set
//  duty           out  8      (high_count<<8)/period_count, saturated to 8'hFF
//  duty_valid     out  1      1-cycle pulse when duty updated
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, prescaler/counters 0, synchroniser flops 0.
//  - Edge detect on last sync stage vs. its delayed copy; edge seen SYNC_STAGES+1 clk after pin.
//  - Prescaler: counts 0..2^div-1, tick when at max; div=0 -> tick every cycle. Cleared on each rise.
//  - Counter cnt: cleared on rise cycle; +1 on each tick cycle otherwise; saturates at all-ones.
//  - FSM IDLE: wait rise -> HIGH (cnt=0). Falls ignored in IDLE.
//  - HIGH: on fall, hi_tmp <= cnt+tick (ticks in (rise,fall]) -> LOW.
//  - LOW: on rise, high_count<=hi_tmp, period_count<=cnt+tick (saturating), meas_valid=1 next
//    cycle, stuck<=0, cnt restarts -> HIGH. Rise and publish share one cycle; no gap.
//  - Saturation (cnt all-ones with tick, HIGH or LOW): stuck<=1, stuck_level<=sync level,
//    -> IDLE; no meas_valid; previous counts held. Stuck clears only on next publish or en=0.
//  - Zero-tick phases (div>0, short pulses) published as-is, no filtering.
//  - en=0: FSM->IDLE, prescaler/cnt cleared, stuck cleared, published counts/duty held;
//    re-enable needs a full rise-fall-rise before next meas_valid.
//  - rst_n low mid-operation: immediate return to reset values, no pulse emitted.
// CONFIGURATION
//  PWM_CAPTURE_DUTY_EN defined: restoring divider, dividend {high_count,8'h00} (CNT_W+8 bits),
//    divisor period_count; starts on meas_valid, duty_valid exactly CNT_W+8 clk later.
//    Quotient >255 -> 8'hFF; period_count==0 -> duty=8'h00 with normal duty_valid timing.
//    New meas_valid while busy aborts and restarts with new values (old result dropped).
//    en=0 aborts divider, duty holds.
//  Undefined: no divider logic; duty=8'h00, duty_valid=0 constantly.
// TESTING
//  1. div=0, 10 clk high/10 low -> high_count=10, period_count=20, duty=128 (8'h80) after 24 clk.
//  2. div=2, 30 high/70 low -> high_count=7, period_count=25, duty=71 (8'h47).
//  3. div=0, pwm_in held 1 >65535 clk -> stuck=1, stuck_level=1, no meas_valid; then
//     3 normal periods -> stuck=0 on first new meas_valid.
//  4. div=0 running, en=0 mid-HIGH for 50 clk then en=1 -> counts held, no pulse until
//     full rise-fall-rise; first result correct.
//  5. rst_n asserted mid-LOW -> all outputs 0 within same cycle, no meas_valid/duty_valid.
//  6. Periods of 8 clk (div=0, 4/4) back-to-back with DUTY_EN -> divider aborts each time,
//     no duty_valid; slow to 40 clk period -> duty=128.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM input capture: synchronises pwm_in and measures the high phase and the full period in prescaled ticks.
// Define PWM_CAPTURE_DUTY_EN to add a serial divider that reports an 8-bit duty cycle after each measurement.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             en,
  input  logic [3:0]       reg_capture_divider,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] period_count,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level,
  output logic [7:0]       duty,
  output logic             duty_valid
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl_dly_q;
  logic                   level, rise, fall;
  logic [14:0]            pre_q, pre_d, pre_max;
  logic                   tick, sat;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  state_e                 state_q, state_d;
  logic                   capture_hi, publish, go_stuck;
  logic [CNT_W-1:0]       hi_tmp_q, hi_tmp_d, high_q, high_d, period_q, period_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   stuck_q, stuck_d, stuck_level_q, stuck_level_d;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
  assign level   = sync_q[SYNC_STAGES-1];
  assign rise    = level & ~lvl_dly_q;
  assign fall    = ~level & lvl_dly_q;

  // Terminal prescaler count is 2^div-1; div=0 gives a tick every cycle.
  assign pre_max = ~(15'h7FFF << reg_capture_divider);
  assign tick    = en && (pre_q == pre_max);
  assign sat     = tick && (cnt_q == CNT_MAX);
  assign cnt_inc = (tick && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

  // NOTE: every signal written in an always_comb gets a default at the top so no latch is inferred.
  always_comb begin
    pre_d = pre_q + 1'b1;
    if (!en || rise || tick) pre_d = '0;
    cnt_d = cnt_inc;
    if (!en || rise) cnt_d = '0;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_d = HIGH;
        HIGH:    if (fall) state_d = LOW;  else if (sat) state_d = IDLE;
        LOW:     if (rise) state_d = HIGH; else if (sat) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    capture_hi = en && state_q == HIGH && fall;
    publish    = en && state_q == LOW && rise;
    go_stuck   = en && sat && ((state_q == HIGH && !fall) || (state_q == LOW && !rise));
  end

  always_comb begin
    hi_tmp_d      = capture_hi ? cnt_inc : hi_tmp_q;
    high_d        = publish ? hi_tmp_q : high_q;
    period_d      = publish ? cnt_inc : period_q;
    meas_valid_d  = publish;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;
    if (go_stuck) begin
      stuck_d       = 1'b1;
      stuck_level_d = level;
    end
    if (publish || !en) begin
      stuck_d       = 1'b0;
      stuck_level_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      lvl_dly_q     <= 1'b0;
      pre_q         <= '0;
      cnt_q         <= '0;
      state_q       <= IDLE;
      hi_tmp_q      <= '0;
      high_q        <= '0;
      period_q      <= '0;
      meas_valid_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      lvl_dly_q     <= level;
      pre_q         <= pre_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      hi_tmp_q      <= hi_tmp_d;
      high_q        <= high_d;
      period_q      <= period_d;
      meas_valid_q  <= meas_valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign high_count   = high_q;
  assign period_count = period_q;
  assign meas_valid   = meas_valid_q;
  assign stuck        = stuck_q;
  assign stuck_level  = stuck_level_q;

`ifdef PWM_CAPTURE_DUTY_EN
  localparam int DIV_N  = CNT_W + 8;
  localparam int ITER_W = $clog2(DIV_N + 1);

  logic              busy_q, busy_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0]  rem_q, rem_d, rem_in, rem_nxt;
  logic [DIV_N-1:0]  quo_q, quo_d, quo_in, quo_nxt;
  logic [CNT_W:0]    rem_sh;
  logic              take, div_start;
  logic [7:0]        duty_q, duty_d;
  logic              duty_valid_q, duty_valid_d;

  // The first restoring step runs in the meas_valid cycle itself, so the last lands DIV_N-1 cycles later.
  assign div_start = meas_valid_q;

  always_comb begin
    rem_in = rem_q;
    quo_in = quo_q;
    if (div_start) begin
      rem_in = '0;
      quo_in = {high_q, 8'h00};
    end
    rem_sh  = {rem_in, quo_in[DIV_N-1]};
    take    = rem_sh >= {1'b0, period_q};
    rem_nxt = take ? CNT_W'(rem_sh - {1'b0, period_q}) : rem_sh[CNT_W-1:0];
    quo_nxt = {quo_in[DIV_N-2:0], take};

    busy_d       = busy_q;
    iter_d       = iter_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    if (!en) begin
      busy_d = 1'b0;
    end else if (div_start || busy_q) begin
      rem_d = rem_nxt;
      quo_d = quo_nxt;
      if (!div_start && iter_q == ITER_W'(DIV_N - 1)) begin
        busy_d       = 1'b0;
        duty_valid_d = 1'b1;
        if (period_q == '0)            duty_d = 8'h00;
        else if (|quo_nxt[DIV_N-1:8])  duty_d = 8'hFF;
        else                           duty_d = quo_nxt[7:0];
      end else begin
        busy_d = 1'b1;
        iter_d = div_start ? ITER_W'(1) : iter_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      iter_q       <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      iter_q       <= iter_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
`else
  assign duty       = 8'h00;
  assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: expected counts are queued as each PWM cycle is driven and
// checked when meas_valid fires; duty results are checked for value and latency when built with the divider.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  div = 4'd0;
  logic [15:0] high_count, period_count;
  logic        meas_valid, stuck, stuck_level, duty_valid;
  logic [7:0]  duty;

  pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pwm_in              (pwm_in),
    .en                  (en),
    .reg_capture_divider (div),
    .high_count          (high_count),
    .period_count        (period_count),
    .meas_valid          (meas_valid),
    .stuck               (stuck),
    .stuck_level         (stuck_level),
    .duty                (duty),
    .duty_valid          (duty_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] per;
  } meas_t;

  meas_t       exp_q[$];
  int          vectors = 0;
  int          errors = 0;
  int          ncyc = 0;
  int          duty_seen = 0;
  logic [15:0] last_hi = '0;
  logic [15:0] last_per = '0;
`ifdef PWM_CAPTURE_DUTY_EN
  logic        duty_pend = 1'b0;
  int          duty_start = 0;
  logic [7:0]  duty_exp = '0;
`endif

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [7:0] duty_model(input logic [15:0] hi, input logic [15:0] per);
    int q;
    if (per == 16'd0) return 8'h00;
    q = (int'(hi) * 256) / int'(per);
    return (q > 255) ? 8'hFF : 8'(q);
  endfunction

  always @(negedge clk) begin : monitor
    meas_t e;
    ncyc++;
    if (duty_valid) begin
      duty_seen++;
      vectors++;
`ifdef PWM_CAPTURE_DUTY_EN
      if (!duty_pend || ncyc != duty_start + 24 || duty !== duty_exp) begin
        errors++;
        $display("FAIL duty_result: got duty=%0d at +%0d clk (pending=%0b), want duty=%0d at +24 clk",
                 duty, ncyc - duty_start, duty_pend, duty_exp);
      end
      duty_pend = 1'b0;
`else
      errors++;
      $display("FAIL duty_valid_disabled: got duty_valid=1 duty=%0d, want no duty_valid", duty);
`endif
    end
`ifdef PWM_CAPTURE_DUTY_EN
    if (duty_pend && ncyc > duty_start + 24) begin
      vectors++;
      errors++;
      $display("FAIL duty_timeout: got no duty_valid, want duty=%0d at +24 clk", duty_exp);
      duty_pend = 1'b0;
    end
`endif
    if (meas_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL meas_unexpected: got meas_valid hi=%0d per=%0d, want no pulse", high_count, period_count);
      end else begin
        e = exp_q.pop_front();
        if (high_count !== e.hi || period_count !== e.per || stuck !== 1'b0) begin
          errors++;
          $display("FAIL meas_counts: got hi=%0d per=%0d stuck=%0b, want hi=%0d per=%0d stuck=0",
                   high_count, period_count, stuck, e.hi, e.per);
        end
        last_hi  = e.hi;
        last_per = e.per;
`ifdef PWM_CAPTURE_DUTY_EN
        duty_pend  = 1'b1;
        duty_start = ncyc;
        duty_exp   = duty_model(e.hi, e.per);
`else
        vectors++;
        if (duty !== 8'h00) begin
          errors++;
          $display("FAIL duty_tied_off: got duty=%0d, want 0", duty);
        end
`endif
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pwm_cycle(input int hi, input int lo);
    meas_t e;
    e.hi  = sat16(hi >> div);
    e.per = sat16((hi + lo) >> div);
    exp_q.push_back(e);
    pwm_in = 1'b1;
    cycles(hi);
    pwm_in = 1'b0;
    cycles(lo);
  endtask

  // Closing rise publishes the last queued cycle, then waits out any divider run.
  task automatic finish_run(input string name);
    pwm_in = 1'b1;
    cycles(8);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_meas: got %0d pending, want 0", name, exp_q.size());
    end
    cycles(30);
`ifdef PWM_CAPTURE_DUTY_EN
    vectors++;
    if (duty_pend) begin
      errors++;
      $display("FAIL %s_missing_duty: got pending duty, want duty_valid seen");
    end
`endif
  endtask

  task automatic disable_capture(input int n);
    en     = 1'b0;
    pwm_in = 1'b0;
    exp_q.delete();
`ifdef PWM_CAPTURE_DUTY_EN
    duty_pend = 1'b0;
`endif
    cycles(n);
    en = 1'b1;
    cycles(4);
  endtask

  task automatic run_pattern(input string name, input logic [3:0] d, input int hi, input int lo, input int n);
    div = d;
    cycles(2);
    for (int i = 0; i < n; i++) pwm_cycle(hi, lo);
    finish_run(name);
    disable_capture(4);
  endtask

  task automatic check_zero_outputs(input string name);
    vectors++;
    if (high_count !== '0 || period_count !== '0 || meas_valid !== 1'b0 || stuck !== 1'b0 ||
        stuck_level !== 1'b0 || duty !== 8'h00 || duty_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: got hi=%0d per=%0d mv=%0b stuck=%0b lvl=%0b duty=%0d dv=%0b, want all 0",
               name, high_count, period_count, meas_valid, stuck, stuck_level, duty, duty_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(3);
    check_zero_outputs("reset_state");
    rst_n = 1'b1;
    cycles(3);
    check_zero_outputs("post_reset_idle");
    en = 1'b1;
    cycles(4);
  endtask

  task automatic test_patterns();
    run_pattern("div0_10_10", 4'd0, 10, 10, 2);
    run_pattern("div2_30_70", 4'd2, 30, 70, 2);
    run_pattern("div1_7_13", 4'd1, 7, 13, 1);
    run_pattern("zero_high", 4'd3, 3, 13, 1);
    run_pattern("zero_period", 4'd4, 3, 5, 1);
    run_pattern("duty_sat", 4'd2, 8, 3, 1);
    run_pattern("div0_200_50", 4'd0, 200, 50, 1);
  endtask

  task automatic test_stuck();
    div    = 4'd0;
    pwm_in = 1'b1;
    cycles(65545);
    vectors++;
    if (stuck !== 1'b1 || stuck_level !== 1'b1 || high_count !== last_hi || period_count !== last_per) begin
      errors++;
      $display("FAIL stuck_high: got stuck=%0b lvl=%0b hi=%0d per=%0d, want 1 1 %0d %0d",
               stuck, stuck_level, high_count, period_count, last_hi, last_per);
    end
    pwm_in = 1'b0;
    cycles(10);
    vectors++;
    if (stuck !== 1'b1) begin
      errors++;
      $display("FAIL stuck_hold: got stuck=%0b, want 1", stuck);
    end
    for (int i = 0; i < 3; i++) pwm_cycle(10, 10);
    finish_run("stuck_recover");
    vectors++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_clear: got stuck=%0b, want 0", stuck);
    end
    disable_capture(4);
  endtask

  task automatic test_enable();
    div = 4'd0;
    pwm_cycle(10, 10);
    pwm_cycle(10, 10);
    pwm_in = 1'b1;
    cycles(8);
    en = 1'b0;
`ifdef PWM_CAPTURE_DUTY_EN
    duty_pend = 1'b0;
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL en_pre_disable: got %0d pending, want 0", exp_q.size());
    end
    cycles(50);
    vectors++;
    if (high_count !== 16'd10 || period_count !== 16'd20 || stuck !== 1'b0) begin
      errors++;
      $display("FAIL en_hold: got hi=%0d per=%0d stuck=%0b, want 10 20 0", high_count, period_count, stuck);
    end
    en = 1'b1;
    cycles(5);
    pwm_in = 1'b0;
    cycles(10);
    pwm_cycle(12, 8);
    pwm_cycle(6, 14);
    finish_run("en_resume");
    disable_capture(4);
  endtask

  task automatic test_reset_mid_low();
    div = 4'd0;
    pwm_cycle(10, 10);
    pwm_in = 1'b1;
    cycles(10);
    pwm_in = 1'b0;
    cycles(4);
    rst_n = 1'b0;
    exp_q.delete();
`ifdef PWM_CAPTURE_DUTY_EN
    duty_pend = 1'b0;
`endif
    #1;
    check_zero_outputs("reset_async");
    cycles(3);
    rst_n = 1'b1;
    cycles(30);
    check_zero_outputs("reset_no_pulse");
    en = 1'b1;
    cycles(4);
  endtask

  task automatic test_back_to_back();
    int seen0;
    div   = 4'd0;
    seen0 = duty_seen;
    for (int i = 0; i < 6; i++) pwm_cycle(4, 4);
    vectors++;
    if (duty_seen != seen0) begin
      errors++;
      $display("FAIL b2b_abort: got %0d duty_valid, want 0", duty_seen - seen0);
    end
    pwm_cycle(20, 20);
    pwm_cycle(20, 20);
    finish_run("b2b_slow");
    disable_capture(4);
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_stuck();
    test_enable();
    test_reset_mid_low();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
